// File: rtl/reservation_alu2_issue.sv
// ALU2 reservation station issue controller: allocates four entries,
// tracks their age and issues the oldest ready entry to ALU2.
module reservation_alu2_issue #(
  parameter int P_PAYLOAD_W = 128
) (
  input  logic                       iCLOCK,
  input  logic                       iRESET,
  input  logic                       iFLUSH,
  input  logic                       iDISPATCH_VALID,
  output logic                       oDISPATCH_LOCK,
  output logic [3:0]                 oENTRY_REGIST,
  output logic [3:0]                 oENTRY_REMOVE,
  output logic [3:0]                 oENTRY_EXOUT,
  input  logic [3:0]                 iENTRY_VALID,
  input  logic [3:0]                 iENTRY_MATCHING,
  input  logic [3:0]                 iENTRY_LOCK,
  input  logic [4*P_PAYLOAD_W-1:0]   iENTRY_PAYLOAD,
  output logic                       oEXE_VALID,
  output logic [P_PAYLOAD_W-1:0]     oEXE_PAYLOAD,
  output logic [1:0]                 oEXE_ENTRY,
  input  logic                       iEXE_BUSY,
  output logic [2:0]                 oCOUNT
);

  logic [3:0]             occupied;
  logic [1:0]             queue [4];
  logic [2:0]             count;
  logic                   exe_valid;
  logic [P_PAYLOAD_W-1:0] exe_payload;
  logic [1:0]             exe_entry;

  logic [3:0] free;
  logic [3:0] ready;
  logic       has_free;
  logic [1:0] alloc_idx;
  logic       alloc;
  logic       found;
  logic [1:0] sel_slot;
  logic [1:0] issue_idx;
  logic       issue;
  logic [1:0] q_next [4];
  logic [2:0] cnt_next;

  assign free     = ~occupied & ~iENTRY_LOCK;
  assign has_free = |free;
  assign ready    = occupied & iENTRY_VALID & iENTRY_MATCHING;
  assign alloc    = iDISPATCH_VALID & has_free & ~iFLUSH;

  // lowest-index free entry is the allocation target
  always_comb begin
    alloc_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (free[i]) alloc_idx = 2'(i);
    end
  end

  // oldest ready entry: lowest age-queue slot whose entry is ready
  always_comb begin
    found    = 1'b0;
    sel_slot = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if ((3'(k) < count) && ready[queue[k]]) begin
        found    = 1'b1;
        sel_slot = 2'(k);
      end
    end
  end

  assign issue_idx = queue[sel_slot];
  assign issue = found & (~exe_valid | ~iEXE_BUSY) & ~iFLUSH;

  // age queue: drop the issued slot first, then append at the tail
  always_comb begin
    for (int k = 0; k < 4; k++) q_next[k] = queue[k];
    cnt_next = count;
    if (issue) begin
      for (int k = 0; k < 3; k++) begin
        if (2'(k) >= sel_slot) q_next[k] = queue[k+1];
      end
      cnt_next = count - 3'd1;
    end
    if (alloc) begin
      q_next[cnt_next[1:0]] = alloc_idx;
      cnt_next = cnt_next + 3'd1;
    end
  end

  assign oDISPATCH_LOCK = ~has_free;
  assign oENTRY_REGIST  = alloc ? (4'b0001 << alloc_idx) : 4'b0000;
  assign oENTRY_EXOUT   = issue ? (4'b0001 << issue_idx) : 4'b0000;
  assign oENTRY_REMOVE  = {4{iFLUSH}};
  assign oEXE_VALID     = exe_valid;
  assign oEXE_PAYLOAD   = exe_payload;
  assign oEXE_ENTRY     = exe_entry;
  assign oCOUNT         = count;

  // occupancy, age queue and output register update
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      occupied    <= 4'b0000;
      count       <= 3'd0;
      for (int k = 0; k < 4; k++) queue[k] <= 2'd0;
      exe_valid   <= 1'b0;
      exe_payload <= '0;
      exe_entry   <= 2'd0;
    end else if (iFLUSH) begin
      occupied  <= 4'b0000;
      count     <= 3'd0;
      for (int k = 0; k < 4; k++) queue[k] <= 2'd0;
      exe_valid <= 1'b0;
    end else begin
      occupied <= (occupied & ~oENTRY_EXOUT) | oENTRY_REGIST;
      count    <= cnt_next;
      for (int k = 0; k < 4; k++) queue[k] <= q_next[k];
      if (issue) begin
        exe_valid   <= 1'b1;
        exe_payload <= iENTRY_PAYLOAD[issue_idx*P_PAYLOAD_W +: P_PAYLOAD_W];
        exe_entry   <= issue_idx;
      end else if (!iEXE_BUSY) begin
        exe_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reservation_alu2_issue.sv
// Bench for reservation_alu2_issue: entry stub, queue-based reference
// model, directed scenarios followed by random traffic.
module tb_reservation_alu2_issue;

  localparam int PW = 128;

  logic          clk = 1'b0;
  logic          rst, flush, dv, busy;
  logic          d_lock, e_valid;
  logic [3:0]    regist, remove, exout;
  logic [3:0]    ev, em, el;
  logic [PW-1:0] ep [4];
  logic [PW-1:0] e_pl;
  logic [1:0]    e_ent;
  logic [2:0]    cnt;

  reservation_alu2_issue #(.P_PAYLOAD_W(PW)) dut (
    .iCLOCK(clk),
    .iRESET(rst),
    .iFLUSH(flush),
    .iDISPATCH_VALID(dv),
    .oDISPATCH_LOCK(d_lock),
    .oENTRY_REGIST(regist),
    .oENTRY_REMOVE(remove),
    .oENTRY_EXOUT(exout),
    .iENTRY_VALID(ev),
    .iENTRY_MATCHING(em & ev),
    .iENTRY_LOCK(el),
    .iENTRY_PAYLOAD({ep[3], ep[2], ep[1], ep[0]}),
    .oEXE_VALID(e_valid),
    .oEXE_PAYLOAD(e_pl),
    .oEXE_ENTRY(e_ent),
    .iEXE_BUSY(busy),
    .oCOUNT(cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [3:0]    m_occ;
  int            m_q [$];
  logic          m_v;
  logic [PW-1:0] m_pl;
  logic [1:0]    m_ent;
  // model decisions for the current cycle
  logic          x_alloc, x_issue;
  int            x_aidx, x_slot, x_iidx;
  // captured strobes for the entry stub
  logic [3:0]    c_reg, c_exo, c_rem;
  logic [PW-1:0] pl_next;

  task automatic chk(input string tag, input logic [PW-1:0] got,
                     input logic [PW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_check();
    logic [3:0] fr;
    logic [3:0] rdy;
    fr = ~m_occ & ~el;
    rdy = m_occ & ev & em;
    x_alloc = dv && (fr != 0) && !flush;
    x_aidx = 0;
    for (int i = 0; i < 4; i++) begin
      if (fr[i]) begin
        x_aidx = i;
        break;
      end
    end
    x_slot = -1;
    foreach (m_q[k]) begin
      if (x_slot < 0 && rdy[m_q[k]]) x_slot = k;
    end
    x_issue = (x_slot >= 0) && (!m_v || !busy) && !flush;
    x_iidx = x_issue ? m_q[x_slot] : 0;
    chk("lock", PW'(d_lock), PW'(fr == 0));
    chk("regist", PW'(regist), x_alloc ? PW'(1) << x_aidx : '0);
    chk("exout", PW'(exout), x_issue ? PW'(1) << x_iidx : '0);
    chk("remove", PW'(remove), flush ? PW'(15) : '0);
    chk("exe_valid", PW'(e_valid), PW'(m_v));
    chk("exe_payload", e_pl, m_pl);
    chk("exe_entry", PW'(e_ent), PW'(m_ent));
    chk("count", PW'(cnt), PW'(m_q.size()));
  endtask

  task automatic settle();
    @(negedge clk);
    c_reg = regist;
    c_exo = exout;
    c_rem = remove;
    if (!rst) model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      m_occ = 0; m_q.delete(); m_v = 0; m_pl = '0; m_ent = 0;
      ev = 0; em = 0; el = 0;
    end else begin
      if (flush) begin
        m_occ = 0; m_q.delete(); m_v = 0;
      end else begin
        if (x_issue) begin
          m_pl = ep[x_iidx];
          m_ent = 2'(x_iidx);
          m_v = 1;
          m_occ[x_iidx] = 0;
          m_q.delete(x_slot);
        end else if (!busy) begin
          m_v = 0;
        end
        if (x_alloc) begin
          m_occ[x_aidx] = 1;
          m_q.push_back(x_aidx);
        end
      end
      for (int i = 0; i < 4; i++) begin
        el[i] = c_reg[i] | c_exo[i] | c_rem[i];
        if (c_rem[i] || c_exo[i]) begin
          ev[i] = 0; em[i] = 0;
        end else if (c_reg[i]) begin
          ev[i] = 1; em[i] = 0; ep[i] = pl_next;
        end
      end
    end
    pl_next = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  logic [PW-1:0] saved;

  initial begin
    rst = 1; flush = 0; dv = 0; busy = 0;
    ev = 0; em = 0; el = 0;
    for (int i = 0; i < 4; i++) ep[i] = '0;
    pl_next = '0;
    m_occ = 0; m_v = 0; m_pl = '0; m_ent = 0;
    x_alloc = 0; x_issue = 0; x_aidx = 0; x_slot = -1; x_iidx = 0;
    #1;
    // reset with random inputs
    for (int c = 0; c < 2; c++) begin
      flush = 1'($urandom); dv = 1'($urandom); busy = 1'($urandom);
      cyc();
    end
    rst = 0; flush = 0; dv = 0; busy = 0;
    settle();
    chk("rst_valid", PW'(e_valid), '0);
    chk("rst_count", PW'(cnt), '0);
    chk("rst_payload", e_pl, '0);
    chk("rst_lock", PW'(d_lock), '0);
    tick();

    // single instruction
    dv = 1; pl_next = PW'(8'hA5);
    settle();
    chk("single_regist", PW'(regist), PW'(4'b0001));
    tick();
    dv = 0; em[0] = 1;
    settle();
    chk("single_exout", PW'(exout), PW'(4'b0001));
    tick();
    settle();
    chk("single_valid", PW'(e_valid), PW'(1));
    chk("single_payload", e_pl, PW'(8'hA5));
    chk("single_count", PW'(cnt), '0);
    tick();
    cyc();

    // age order
    dv = 1;
    for (int c = 0; c < 3; c++) cyc();
    dv = 0; em[1] = 1; em[2] = 1;
    settle();
    chk("age_first", PW'(exout), PW'(4'b0010));
    tick();
    settle();
    chk("age_second", PW'(exout), PW'(4'b0100));
    chk("age_entry1", PW'(e_ent), PW'(1));
    tick();
    settle();
    chk("age_entry2", PW'(e_ent), PW'(2));
    tick();

    // flush to empty, then fill
    flush = 1;
    settle();
    chk("fl0_remove", PW'(remove), PW'(4'b1111));
    tick();
    flush = 0;
    cyc();
    dv = 1;
    for (int c = 0; c < 4; c++) cyc();
    em[3] = 1;
    settle();
    chk("full_count", PW'(cnt), PW'(4));
    chk("full_lock", PW'(d_lock), PW'(1));
    chk("full_exout", PW'(exout), PW'(4'b1000));
    tick();
    settle();
    chk("reuse_lock", PW'(d_lock), PW'(1));
    tick();
    settle();
    chk("reuse_unlock", PW'(d_lock), '0);
    chk("reuse_regist", PW'(regist), PW'(4'b1000));
    tick();
    dv = 0;

    // backpressure
    em[0] = 1; em[1] = 1;
    settle();
    chk("bp_exout0", PW'(exout), PW'(4'b0001));
    saved = ep[0];
    tick();
    busy = 1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("bp_no_exout", PW'(exout), '0);
      chk("bp_hold_pl", e_pl, saved);
      chk("bp_hold_ent", PW'(e_ent), '0);
      tick();
    end
    busy = 0;
    settle();
    chk("bp_exout1", PW'(exout), PW'(4'b0010));
    tick();
    busy = 1;
    settle();
    chk("bp_entry1", PW'(e_ent), PW'(1));
    tick();
    dv = 1;
    settle();
    chk("fl_alloc", PW'(regist), PW'(4'b0001));
    tick();

    // flush while busy with three occupied entries
    flush = 1; em[2] = 1;
    settle();
    chk("fl_count3", PW'(cnt), PW'(3));
    chk("fl_remove", PW'(remove), PW'(4'b1111));
    chk("fl_regist", PW'(regist), '0);
    chk("fl_exout", PW'(exout), '0);
    tick();
    flush = 0; dv = 0; busy = 0;
    settle();
    chk("fl_valid", PW'(e_valid), '0);
    chk("fl_count", PW'(cnt), '0);
    tick();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      dv = ($urandom_range(0, 9) < 6);
      busy = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 4; i++) begin
        if (ev[i] && $urandom_range(0, 3) == 0) em[i] = 1;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
